// File: rtl/divrem_pkg.sv
// Shared constants for the iterative DIV/DIVU/REM/REMU unit.
// DIVREM_RADIX4_EN selects two quotient bits per iteration.
package divrem_pkg;

  localparam int DIVREM_XLEN = 32;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic q_neg;
    logic r_neg;
    logic sel_rem;
  } divrem_sign_t;

  function automatic int divrem_iter(input int xlen);
`ifdef DIVREM_RADIX4_EN
    return xlen / 2;
`else
    return xlen;
`endif
  endfunction

  localparam int DIVREM_ITER = divrem_iter(DIVREM_XLEN);

endpackage

// File: rtl/divrem_unit_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when non-negative.
module divrem_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            dbit_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic            qbit_o
);

  logic [XLEN+1:0] diff;

  assign diff   = {rem_i, dbit_i} - {2'b00, dvs_i};
  assign qbit_o = ~diff[XLEN+1];
  assign rem_o  = qbit_o ? diff[XLEN:0]
                         : {rem_i[XLEN-1:0], dbit_i};

endmodule

// File: rtl/divrem_unit.sv
// Iterative DIV/DIVU/REM/REMU unit with start/ready handshake.
// Define DIVREM_RADIX4_EN for two quotient bits per cycle.
module divrem_unit
  import divrem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = 5
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iStart,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iAdvance,
  input  logic            iFlush,
  output logic            oBusy,
  output logic            oReady,
  output logic [XLEN-1:0] oResult
);

  localparam int ITER = divrem_iter(XLEN);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ITER - 1);

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  divrem_sign_t    sgn_q, sgn_d;

  logic            signed_op;
  logic            a_neg, b_neg;
  logic            b_zero, ovf;
  logic [XLEN:0]   rem_s1, rem_nx;
  logic            q_s1;
  logic [XLEN-1:0] dvd_nx;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign signed_op = (iFunct3 == FUNCT3_DIV)
                   | (iFunct3 == FUNCT3_REM);
  assign a_neg  = signed_op & iA[XLEN-1];
  assign b_neg  = signed_op & iB[XLEN-1];
  assign b_zero = (iB == '0);
  assign ovf    = signed_op
                & (iA == {1'b1, {(XLEN-1){1'b0}}})
                & (iB == '1);

  divrem_step #(.XLEN(XLEN)) u_step0 (
    .rem_i  (rem_q),
    .dbit_i (dvd_q[XLEN-1]),
    .dvs_i  (dvs_q),
    .rem_o  (rem_s1),
    .qbit_o (q_s1)
  );

`ifdef DIVREM_RADIX4_EN
  logic q_s2;

  divrem_step #(.XLEN(XLEN)) u_step1 (
    .rem_i  (rem_s1),
    .dbit_i (dvd_q[XLEN-2]),
    .dvs_i  (dvs_q),
    .rem_o  (rem_nx),
    .qbit_o (q_s2)
  );

  assign dvd_nx = {dvd_q[XLEN-3:0], q_s1, q_s2};
`else
  assign rem_nx = rem_s1;
  assign dvd_nx = {dvd_q[XLEN-2:0], q_s1};
`endif

  // dvd_nx holds the finished quotient on the last iteration
  assign quo_fix = sgn_q.q_neg ? -dvd_nx : dvd_nx;
  assign rem_fix = sgn_q.r_neg ? -rem_nx[XLEN-1:0]
                               : rem_nx[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
    if (iFlush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          if (iStart) begin
            dvd_d = a_neg ? -iA : iA;
            dvs_d = b_neg ? -iB : iB;
            rem_d = '0;
            cnt_d = '0;
            sgn_d = '{q_neg:   a_neg ^ b_neg,
                      r_neg:   a_neg,
                      sel_rem: iFunct3[1]};
            if (b_zero) begin
              res_d   = iFunct3[1] ? iA : '1;
              state_d = ST_DONE;
            end else if (ovf) begin
              res_d   = iFunct3[1] ? '0 : iA;
              state_d = ST_DONE;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        (state_q == ST_CALC): begin
          rem_d = rem_nx;
          dvd_d = dvd_nx;
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNT_LAST) begin
            res_d   = sgn_q.sel_rem ? rem_fix : quo_fix;
            state_d = ST_DONE;
          end
        end
        (state_q == ST_DONE): begin
          if (iAdvance) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
    end
  end

  assign oBusy   = (state_q == ST_CALC);
  assign oReady  = (state_q == ST_DONE);
  assign oResult = res_q;

endmodule

// File: tb/tb_divrem_unit.sv
// Scoreboard bench for divrem_unit: directed vectors,
// monitor checks result and ready latency on each handshake.
module tb_divrem_unit;

`ifdef DIVREM_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        iCLK = 1'b0;
  logic        iRSTn = 1'b0;
  logic        iStart = 1'b0;
  logic [2:0]  iFunct3 = 3'b101;
  logic [31:0] iA = '0;
  logic [31:0] iB = '0;
  logic        iAdvance = 1'b0;
  logic        iFlush = 1'b0;
  logic        oBusy, oReady;
  logic [31:0] oResult;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   rdy_cyc = 0;
  bit   rdy_seen = 1'b0;

  divrem_unit #(.XLEN(32), .CNTW(5)) dut (
    .iCLK     (iCLK),
    .iRSTn    (iRSTn),
    .iStart   (iStart),
    .iFunct3  (iFunct3),
    .iA       (iA),
    .iB       (iB),
    .iAdvance (iAdvance),
    .iFlush   (iFlush),
    .oBusy    (oBusy),
    .oReady   (oReady),
    .oResult  (oResult)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops on every accepted result
  initial begin
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (iRSTn) begin
        if (oReady && !rdy_seen) begin
          rdy_seen = 1'b1;
          rdy_cyc  = cyc;
        end
        if (oReady && iAdvance) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got %h", oResult);
          end else begin
            e = sb_q.pop_front();
            check("result", oResult, e.res);
            check("latency", 32'(rdy_cyc - e.start), 32'(e.lat));
          end
          rdy_seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge iCLK); #1;
      if (oReady) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic issue(input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] r,
                       input int lat);
    @(posedge iCLK); #1;
    iStart  = 1'b1;
    iFunct3 = f3;
    iA      = a;
    iB      = b;
    sb_q.push_back('{res: r, lat: lat, start: cyc});
  endtask

  task automatic recover();
    checks++;
    errors++;
    $display("FAIL timeout: oReady never rose");
    void'(sb_q.pop_back());
    iFlush = 1'b1;
    @(posedge iCLK); #1;
    iFlush = 1'b0;
    iStart = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] r,
                        input int lat);
    bit ok;
    issue(f3, a, b, r, lat);
    wait_ready(ok);
    if (!ok) begin
      recover();
    end else begin
      iAdvance = 1'b1;
      @(posedge iCLK); #1;
      iAdvance = 1'b0;
      iStart   = 1'b0;
    end
  endtask

  initial begin
    #60_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    bit ok;
    int s;
    #1;
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_ready", 32'(oReady), 32'd0);
    check("rst_result", oResult, 32'd0);
    repeat (2) @(posedge iCLK);
    #1 iRSTn = 1'b1;

    run_op(3'b101, 32'd100, 32'd7, 32'd14, LAT);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, LAT);
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT);
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT);
    run_op(3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, LAT);
    run_op(3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, LAT);
    run_op(3'b101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, LAT);
    run_op(3'b111, 32'hFFFFFFFF, 32'h10, 32'hF, LAT);
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 1);
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // flush mid-calculation
    @(posedge iCLK); #1;
    iStart = 1'b1; iFunct3 = 3'b101;
    iA = 32'h0000FFFF; iB = 32'd3;
    s = cyc;
    while (cyc < s + 10) begin
      @(posedge iCLK); #1;
    end
    check("flush_busy_pre", 32'(oBusy), 32'd1);
    iFlush = 1'b1;
    @(posedge iCLK); #1;
    iFlush = 1'b0;
    iStart = 1'b0;
    check("flush_busy", 32'(oBusy), 32'd0);
    check("flush_ready", 32'(oReady), 32'd0);
    repeat (3) @(posedge iCLK);
    #1 check("flush_ready_late", 32'(oReady), 32'd0);
    run_op(3'b101, 32'd9, 32'd3, 32'd3, LAT);

    // hold in DONE without advance
    issue(3'b101, 32'h12345678, 32'h100, 32'h00123456, LAT);
    wait_ready(ok);
    if (!ok) begin
      recover();
    end else begin
      for (int i = 0; i < 4; i++) begin
        iStart = ~iStart;
        iA = 32'hDEAD0000 + 32'(i);
        @(posedge iCLK); #1;
        check("hold_ready", 32'(oReady), 32'd1);
        check("hold_result", oResult, 32'h00123456);
      end
      iStart = 1'b1;
      iAdvance = 1'b1;
      @(posedge iCLK); #1;
      iAdvance = 1'b0;
      iStart = 1'b0;
      check("adv_ready", 32'(oReady), 32'd0);
      check("adv_result", oResult, 32'h00123456);
    end

    // asynchronous reset mid-calculation
    @(posedge iCLK); #1;
    iStart = 1'b1; iFunct3 = 3'b101;
    iA = 32'd1000; iB = 32'd10;
    repeat (5) @(posedge iCLK);
    #2;
    check("pre_rst_busy", 32'(oBusy), 32'd1);
    iRSTn = 1'b0;
    #1;
    check("arst_busy", 32'(oBusy), 32'd0);
    check("arst_ready", 32'(oReady), 32'd0);
    check("arst_result", oResult, 32'd0);
    iStart = 1'b0;
    @(posedge iCLK); #1;
    iRSTn = 1'b1;
    run_op(3'b101, 32'd1000, 32'd10, 32'd100, LAT);

    repeat (2) @(posedge iCLK);
    #1 check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divrem_unit.md
Name: divrem_unit

Overview:
- Iterative multi-cycle DIV/DIVU/REM/REMU execution unit in the EX stage.
- Replaces the fixed-count DIVREM stall timer with a real start/ready handshake.
- Hazard/forwarding unit holds the whole pipeline stalled while iStart && !oReady.
- Result joins the EX ALU-result path, so normal EX->ID and MEM->EX forwarding applies unchanged.

Parameters:
- XLEN, 32, operand/result width.
- CNTW, 5, iteration counter width; must satisfy 2^CNTW >= XLEN.

Ports:
- iCLK  in  1  clock; all state on rising edge.
- iRSTn  in  1  reset; asynchronous, active-low.
- iStart  in  1  EX holds a DivRem instruction; held high until the instruction leaves EX.
- iFunct3  in  3  100=DIV, 101=DIVU, 110=REM, 111=REMU.
- iA  in  XLEN  dividend (Rs1 after forwarding).
- iB  in  XLEN  divisor (Rs2 after forwarding).
- iAdvance  in  1  EX->MEM register loads this cycle (no external stall).
- iFlush  in  1  EX instruction killed (IDEX/EXMEM flush, exception).
- oBusy  out  1  operation in progress (state CALC).
- oReady  out  1  oResult valid for the current EX instruction.
- oResult  out  XLEN  quotient or remainder.

Behaviour:
- Reset (async, iRSTn=0): state IDLE, counter 0, oBusy=0, oReady=0, oResult=0, internal registers 0.
- States:
  - IDLE -> CALC: iStart=1 and not a special case.
  - IDLE -> DONE: iStart=1 and a special case (1-cycle path).
  - CALC -> DONE: after the last iteration.
  - DONE -> IDLE: iAdvance=1.
- Operand capture, IDLE with iStart=1 (registered):
  - Signed ops (DIV, REM): negative operands are stored as their magnitude (two's-complement negation).
  - Result signs are latched: quotient negative if iA[31]^iB[31]; remainder negative if iA[31].
  - Unsigned ops: no conversion, signs latched as positive.
- CALC: restoring division, one quotient bit per cycle, MSB first, XLEN cycles.
  - Partial remainder is XLEN+1 bits.
  - Trial subtract; if non-negative, keep the difference and set the quotient bit to 1.
- Entering DONE: oResult <= quotient or remainder selected by iFunct3[1], sign-corrected.
- Special cases, decided in IDLE, result registered directly:
  - iB=0: quotient = all ones, remainder = iA (any op).
  - DIV/REM with iA=0x80000000 and iB=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Latency: start cycle T, oReady=1 at T+XLEN+1 (normal) or T+1 (special case).
- oReady is a level, high only in DONE, held with oResult stable until iAdvance. This covers a DONE cycle that coincides with an unrelated stall.
- oBusy=1 only in CALC.
- iStart while in CALC or DONE: ignored; operands are not re-sampled.
- iFlush: highest priority in every state.
  - Next state IDLE, oReady=0 next cycle; an iStart in the same cycle is ignored.
  - oResult is not cleared.
- iStart falling while in CALC without iFlush is illegal; no defined result.
- Back-to-back DivRem: DONE+iAdvance -> IDLE, next instruction starts the following cycle (one bubble cycle inside the handshake).

Optional Feature:
- DIVREM_RADIX4_EN defined: two quotient bits per CALC cycle (two cascaded restoring steps), XLEN/2 iterations; normal latency T+XLEN/2+1.
- Not defined: radix-2, latency T+XLEN+1.
- Results, special cases and handshake are identical in both builds.

Decomposition:
- Shared parameter include, alongside the existing Parametros.v definitions:
  - funct3 constants FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU.
  - State encodings ST_IDLE, ST_CALC, ST_DONE.
  - Constant DIVREM_ITER derived from XLEN and DIVREM_RADIX4_EN.
- Sub-module divrem_step: combinational single restoring iteration. Inputs: remainder, dividend bit, divisor. Outputs: next remainder, quotient bit. Instantiated once (radix-2) or twice chained (radix-4).
- Top level holds the FSM, counter, operand/sign registers and result fix-up.

Test Plan:
- DIVU 100/7: oReady at T+33 (T+17 radix-4), oResult=14; REMU same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5 at T+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both at T+1.
- iFlush at cycle T+10 of a DIVU -> IDLE next cycle, oReady stays 0; new iStart DIVU 9/3 -> 3 with full latency.
- Reach DONE with iAdvance=0 for 4 cycles -> oReady and oResult held stable; iStart toggling ignored; iAdvance=1 -> IDLE next cycle.
- Assert iRSTn=0 mid-CALC asynchronously -> oBusy/oReady/oResult 0 immediately; after release a 1000/10 DIVU returns 100.
